// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search sequencer: sequencer states, key width
// and the memory-mux select encodings used alongside the stage enables.
package rc4_pkg;

   localparam int KEY_W = 24;

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      SHUFFLE,
      DECRYPT,
      CHECK,
      NEXT_KEY,
      FOUND,
      FAIL,
      ERROR
   } state_t;

   typedef enum logic [1:0] {
      MEM_NONE = 2'b00,
      MEM_WORK = 2'b01,
      MEM_ENC  = 2'b10,
      MEM_DEC  = 2'b11
   } mem_sel_t;

   function automatic logic is_stage(input state_t s);
      return (s == INIT) || (s == SHUFFLE) || (s == DECRYPT);
   endfunction

endpackage

// File: rtl/stage_timer.sv
// Per-stage watchdog: counts cycles without a completion pulse and flags the cycle
// in which the count would reach STAGE_TIMEOUT.
module stage_timer #(
   parameter logic [15:0] STAGE_TIMEOUT = 16'd4095
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   logic [15:0] count;

   // Combinational so the sequencer leaves the stage on the very edge the count hits the limit.
   assign expired = en && (count == (STAGE_TIMEOUT - 16'd1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/rc4_stage_sequencer.sv
// Walks each candidate key through init/shuffle/decrypt, checks the result and
// advances the key until a legal message is found, the range runs out, or a stage stalls.
module rc4_stage_sequencer
   import rc4_pkg::*;
#(
   parameter logic [KEY_W-1:0] KEY_MAX       = 24'h3FFFFF,
   parameter logic [15:0]      STAGE_TIMEOUT = 16'd4095
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [KEY_W-1:0] key_start,
   input  logic             done_init,
   input  logic             done_shuffle,
   input  logic             done_decrypt,
   input  logic             msg_valid,
   output logic             start_init,
   output logic             start_shuffle,
   output logic             start_decrypt,
   output logic [KEY_W-1:0] secret_key,
   output logic             busy,
   output logic             found,
   output logic             exhausted,
   output logic             timeout_err
);

   state_t state, state_next;
   logic   in_stage;
   logic   stage_done;
   logic   go_accept;
   logic   tmr_clear;
   logic   tmr_en;
   logic   tmr_expired;

   assign in_stage  = is_stage(state);
   assign tmr_en    = in_stage && !stage_done;
   assign tmr_clear = !in_stage || (state_next != state);

   stage_timer #(
      .STAGE_TIMEOUT(STAGE_TIMEOUT)
   ) u_stage_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmr_clear),
      .en     (tmr_en),
      .expired(tmr_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      stage_done = 1'b0;
      go_accept  = 1'b0;
      case (state)
         IDLE, FOUND, FAIL, ERROR: begin
            if (go) begin
               go_accept  = 1'b1;
               state_next = INIT;
            end
         end
         INIT: begin
            stage_done = done_init;
            if (done_init)        state_next = SHUFFLE;
            else if (tmr_expired) state_next = ERROR;
         end
         SHUFFLE: begin
            stage_done = done_shuffle;
            if (done_shuffle)     state_next = DECRYPT;
            else if (tmr_expired) state_next = ERROR;
         end
         DECRYPT: begin
            stage_done = done_decrypt;
            if (done_decrypt)     state_next = CHECK;
            else if (tmr_expired) state_next = ERROR;
         end
         CHECK: begin
            // ">=" also ends a run whose start key was already beyond the range.
            if (msg_valid)                 state_next = FOUND;
            else if (secret_key >= KEY_MAX) state_next = FAIL;
            else                           state_next = NEXT_KEY;
         end
         NEXT_KEY: state_next = INIT;
         default:  state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_init    <= 1'b0;
         start_shuffle <= 1'b0;
         start_decrypt <= 1'b0;
         busy          <= 1'b0;
         secret_key    <= '0;
         found         <= 1'b0;
         exhausted     <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         start_init    <= (state_next == INIT);
         start_shuffle <= (state_next == SHUFFLE);
         start_decrypt <= (state_next == DECRYPT);
         busy          <= is_stage(state_next) || (state_next == CHECK) ||
                          (state_next == NEXT_KEY);
         if (go_accept) begin
            secret_key  <= key_start;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            timeout_err <= 1'b0;
         end else if (state == NEXT_KEY) begin
            secret_key <= secret_key + {{(KEY_W-1){1'b0}}, 1'b1};
         end
         if (state_next == FOUND && state != FOUND) found       <= 1'b1;
         if (state_next == FAIL  && state != FAIL)  exhausted   <= 1'b1;
         if (state_next == ERROR && state != ERROR) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rc4_stage_sequencer.sv
// Bench for rc4_stage_sequencer: a default-parameter instance and a small-range,
// short-timeout instance, each driven against a key-search reference model.
module tb_rc4_stage_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        go;
   logic [23:0] key_start;
   logic        done_init, done_shuffle, done_decrypt, msg_valid;
   bit          sel;

   logic        a_go, a_di, a_ds, a_dd;
   logic        b_go, b_di, b_ds, b_dd;
   logic [2:0]  a_st, b_st, st;
   logic [23:0] a_key, b_key, s_key;
   logic        a_busy, a_found, a_exh, a_terr;
   logic        b_busy, b_found, b_exh, b_terr;
   logic        s_busy, s_found, s_exh, s_terr;

   int total = 0;
   int passed = 0;
   int onehot_bad = 0;

   always #5 clk = ~clk;

   assign a_go = go & ~sel;
   assign a_di = done_init & ~sel;
   assign a_ds = done_shuffle & ~sel;
   assign a_dd = done_decrypt & ~sel;
   assign b_go = go & sel;
   assign b_di = done_init & sel;
   assign b_ds = done_shuffle & sel;
   assign b_dd = done_decrypt & sel;

   assign st     = sel ? b_st    : a_st;
   assign s_key  = sel ? b_key   : a_key;
   assign s_busy = sel ? b_busy  : a_busy;
   assign s_found = sel ? b_found : a_found;
   assign s_exh  = sel ? b_exh   : a_exh;
   assign s_terr = sel ? b_terr  : a_terr;

   rc4_stage_sequencer dut_a (
      .clk(clk), .reset(reset), .go(a_go), .key_start(key_start),
      .done_init(a_di), .done_shuffle(a_ds), .done_decrypt(a_dd), .msg_valid(msg_valid),
      .start_init(a_st[0]), .start_shuffle(a_st[1]), .start_decrypt(a_st[2]),
      .secret_key(a_key), .busy(a_busy), .found(a_found), .exhausted(a_exh),
      .timeout_err(a_terr)
   );

   rc4_stage_sequencer #(.KEY_MAX(24'd3), .STAGE_TIMEOUT(16'd16)) dut_b (
      .clk(clk), .reset(reset), .go(b_go), .key_start(key_start),
      .done_init(b_di), .done_shuffle(b_ds), .done_decrypt(b_dd), .msg_valid(msg_valid),
      .start_init(b_st[0]), .start_shuffle(b_st[1]), .start_decrypt(b_st[2]),
      .secret_key(b_key), .busy(b_busy), .found(b_found), .exhausted(b_exh),
      .timeout_err(b_terr)
   );

   always @(negedge clk) begin
      if (!reset) begin
         if ($countones(a_st) > 1 || $countones(b_st) > 1 ||
             (|a_st && !a_busy) || (|b_st && !b_busy))
            onehot_bad++;
      end
   end

   task automatic do_stage(input int which, input int d);
      for (int i = 1; i < d; i++) @(negedge clk);
      case (which)
         0:       done_init = 1'b1;
         1:       done_shuffle = 1'b1;
         default: done_decrypt = 1'b1;
      endcase
      @(negedge clk);
      done_init = 1'b0; done_shuffle = 1'b0; done_decrypt = 1'b0;
   endtask

   function automatic int pick(input int fixed, input int dmax);
      return (fixed > 0) ? fixed : int'($urandom_range(1, dmax));
   endfunction

   // Model: keys ks, ks+1, ... are tried until one equals vk or the key reaches the range end.
   task automatic run_search(input string name, input logic [23:0] ks, input logic [23:0] vk,
                             input int di, input int ds, input int dd, input int dmax);
      logic [23:0] mk, kmax;
      bit hit;
      kmax = sel ? 24'd3 : 24'h3FFFFF;
      mk = ks;
      hit = 1'b0;
      key_start = ks; go = 1'b1;
      @(negedge clk);
      go = 1'b0; key_start = 24'($urandom);
      for (int p = 0; p < 64; p++) begin
         total++; if (st !== 3'b001) $display("FAIL %s init_start key %h: got %b want 001", name, mk, st); else passed++;
         total++; if (s_key !== mk) $display("FAIL %s secret_key: got %h want %h", name, s_key, mk); else passed++;
         total++; if (s_busy !== 1'b1) $display("FAIL %s busy_in_init: got %b want 1", name, s_busy); else passed++;
         msg_valid = (mk == vk);
         do_stage(0, pick(di, dmax));
         total++; if (st !== 3'b010) $display("FAIL %s shuffle_start: got %b want 010", name, st); else passed++;
         do_stage(1, pick(ds, dmax));
         total++; if (st !== 3'b100) $display("FAIL %s decrypt_start: got %b want 100", name, st); else passed++;
         do_stage(2, pick(dd, dmax));
         total++; if ({st, s_busy} !== 4'b0001) $display("FAIL %s check_state: got %b want 0001", name, {st, s_busy}); else passed++;
         hit = (mk == vk);
         if (hit || mk >= kmax) break;
         @(negedge clk);
         total++; if ({st, s_busy} !== 4'b0001) $display("FAIL %s next_key_state: got %b want 0001", name, {st, s_busy}); else passed++;
         @(negedge clk);
         mk = mk + 24'd1;
      end
      @(negedge clk);
      total++; if ({st, s_busy} !== 4'b0000) $display("FAIL %s idle_after: got %b want 0000", name, {st, s_busy}); else passed++;
      total++; if (s_found !== hit) $display("FAIL %s found: got %b want %b", name, s_found, hit); else passed++;
      total++; if (s_exh !== !hit) $display("FAIL %s exhausted: got %b want %b", name, s_exh, !hit); else passed++;
      total++; if (s_terr !== 1'b0) $display("FAIL %s timeout_err: got %b want 0", name, s_terr); else passed++;
      total++; if (s_key !== mk) $display("FAIL %s final_key: got %h want %h", name, s_key, mk); else passed++;
      repeat (2) @(negedge clk);
      total++; if ({s_found, s_exh, s_key} !== {hit, !hit, mk}) $display("FAIL %s sticky: got %b%b %h want %b%b %h", name, s_found, s_exh, s_key, hit, !hit, mk); else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1; go = 1'b0; key_start = 24'h0;
      done_init = 1'b0; done_shuffle = 1'b0; done_decrypt = 1'b0; msg_valid = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         sel = k[0];
         #1;
         total++; if ({st, s_busy, s_found, s_exh, s_terr} !== 7'b0) $display("FAIL reset_flags inst %0d: got %b want 0", k, {st, s_busy, s_found, s_exh, s_terr}); else passed++;
         total++; if (s_key !== 24'h0) $display("FAIL reset_key inst %0d: got %h want 0", k, s_key); else passed++;
      end
      sel = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_happy_path();
      sel = 1'b0;
      run_search("happy", 24'h000249, 24'h000249, 770, 1540, 330, 1);
   endtask

   task automatic test_search();
      logic [23:0] ks;
      sel = 1'b0;
      run_search("search5", 24'h0, 24'h5, 0, 0, 0, 12);
      for (int r = 0; r < 3; r++) begin
         ks = 24'($urandom_range(100, 5000));
         run_search("search_rand", ks, ks + 24'($urandom_range(0, 3)), 0, 0, 0, 30);
      end
   endtask

   task automatic test_key_bounds();
      sel = 1'b0;
      run_search("over_max", 24'h400000, 24'h0, 0, 0, 0, 8);
      run_search("top_of_range", 24'h3FFFFE, 24'h0, 0, 0, 0, 8);
      run_search("all_ones", 24'hFFFFFF, 24'h0, 0, 0, 0, 8);
   endtask

   task automatic test_exhaust();
      sel = 1'b1;
      run_search("exhaust", 24'h2, 24'hFFFFFF, 0, 0, 0, 16);
      for (int r = 0; r < 3; r++)
         run_search("exhaust_rand", 24'($urandom_range(0, 3)), 24'($urandom_range(0, 7)), 0, 0, 0, 16);
   endtask

   task automatic test_timeout();
      sel = 1'b1; msg_valid = 1'b1;
      key_start = 24'h1; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      do_stage(0, 3);
      total++; if (st !== 3'b010) $display("FAIL to_shuffle_entry: got %b want 010", st); else passed++;
      repeat (15) @(negedge clk);
      total++; if ({st, s_terr} !== 4'b0100) $display("FAIL to_cycle16: got %b want 0100", {st, s_terr}); else passed++;
      @(negedge clk);
      total++; if ({st, s_busy, s_terr, s_found} !== 6'b000010) $display("FAIL to_error: got %b want 000010", {st, s_busy, s_terr, s_found}); else passed++;
      total++; if (s_key !== 24'h1) $display("FAIL to_error_key: got %h want 000001", s_key); else passed++;
      repeat (3) @(negedge clk);
      total++; if (s_terr !== 1'b1) $display("FAIL to_sticky: got %b want 1", s_terr); else passed++;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      total++; if ({st, s_terr} !== 4'b0010) $display("FAIL to_restart: got %b want 0010", {st, s_terr}); else passed++;
      do_stage(0, 2);
      do_stage(1, 16);
      total++; if ({st, s_terr} !== 4'b1000) $display("FAIL to_done_at_limit: got %b want 1000", {st, s_terr}); else passed++;
      do_stage(2, 16);
      total++; if ({st, s_busy} !== 4'b0001) $display("FAIL to_check: got %b want 0001", {st, s_busy}); else passed++;
      @(negedge clk);
      total++; if ({s_busy, s_found, s_terr} !== 3'b010) $display("FAIL to_found: got %b want 010", {s_busy, s_found, s_terr}); else passed++;
   endtask

   task automatic test_stray_and_busy_go();
      logic [23:0] r;
      sel = 1'b0; msg_valid = 1'b1;
      r = 24'($urandom_range(1, 24'h3FFFFF));
      key_start = r; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      done_decrypt = 1'b1; done_shuffle = 1'b1;
      @(negedge clk);
      done_decrypt = 1'b0; done_shuffle = 1'b0;
      total++; if (st !== 3'b001) $display("FAIL stray_done: got %b want 001", st); else passed++;
      key_start = ~r; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      total++; if ({st, s_key} !== {3'b001, r}) $display("FAIL busy_go: got %b %h want 001 %h", st, s_key, r); else passed++;
      do_stage(0, 4);
      total++; if (st !== 3'b010) $display("FAIL stray_shuffle: got %b want 010", st); else passed++;
      do_stage(1, 4);
      do_stage(2, 4);
      @(negedge clk);
      total++; if ({s_busy, s_found, s_key} !== {2'b01, r}) $display("FAIL stray_final: got %b%b %h want 01 %h", s_busy, s_found, s_key, r); else passed++;
   endtask

   task automatic test_reset_mid_decrypt();
      sel = 1'b0; msg_valid = 1'b0;
      key_start = 24'h000123; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      do_stage(0, 2);
      do_stage(1, 2);
      repeat (3) @(negedge clk);
      total++; if (st !== 3'b100) $display("FAIL rst_pre_decrypt: got %b want 100", st); else passed++;
      reset = 1'b1;
      #1;
      total++; if ({st, s_busy, s_found, s_exh, s_terr} !== 7'b0) $display("FAIL rst_async_flags: got %b want 0", {st, s_busy, s_found, s_exh, s_terr}); else passed++;
      total++; if (s_key !== 24'h0) $display("FAIL rst_async_key: got %h want 0", s_key); else passed++;
      @(negedge clk);
      reset = 1'b0; done_decrypt = 1'b1;
      @(negedge clk);
      done_decrypt = 1'b0;
      repeat (3) @(negedge clk);
      total++; if ({st, s_busy, s_found, s_exh, s_terr} !== 7'b0) $display("FAIL rst_stays_idle: got %b want 0", {st, s_busy, s_found, s_exh, s_terr}); else passed++;
   endtask

   initial begin
      test_reset();
      test_happy_path();
      test_search();
      test_key_bounds();
      test_exhaust();
      test_timeout();
      test_stray_and_busy_go();
      test_reset_mid_decrypt();
      total++; if (onehot_bad !== 0) $display("FAIL onehot_monitor: got %0d bad cycles want 0", onehot_bad); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
